// File: rtl/poly_ram_streamer_if.sv
// Stream/RAM bundle for poly_ram_streamer.
// master: the streamer side (drives RAM port and output stream).
// slave : the environment side (RAM model, stream sink, control).
interface poly_ram_streamer_if #(
  parameter int ADDR_W = 11
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              busy;
  logic              done;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [15:0]       ram_dout;
  logic [15:0]       m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (
    input  start, base_addr, ram_dout, m_ready,
    output busy, done, ram_en, ram_addr, ram_we, m_data, m_valid
  );

  modport slave (
    output start, base_addr, ram_dout, m_ready,
    input  busy, done, ram_en, ram_addr, ram_we, m_data, m_valid
  );
endinterface

// File: rtl/poly_ram_streamer.sv
// poly_ram_streamer: fetches N consecutive 16-bit coefficients from one RAM
// port and presents them as a valid/ready stream. A small FIFO plus a
// read-credit check (FIFO occupancy + read in flight) absorbs the 1-cycle RAM
// latency so back-pressure never drops or duplicates a beat.
// Optional feature macro: BITREV_EN (read k uses base_addr + bitrev(k)).
module poly_ram_streamer #(
  parameter int N      = 1024,
  parameter int ADDR_W = 11,
  parameter int FIFO_D = 4
) (
  input  logic                clk,
  input  logic                rst,
  poly_ram_streamer_if.master bus
);
  localparam int CW    = $clog2(FIFO_D) + 1;
  localparam int PW    = $clog2(FIFO_D);
  localparam int LOG2N = $clog2(N);
  localparam logic [ADDR_W:0] NUM      = (ADDR_W+1)'(N);
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(N - 1);
  localparam logic [CW:0]     DEPTH    = (CW+1)'(FIFO_D);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W:0]   issued_r, sent_r;
  logic              inflight_r, done_r;
  logic [15:0]       mem_r [FIFO_D];
  logic [PW-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              issue_s, pop_s, last_s, start_ok_s, valid_s;
  logic [CW:0]       occ_s;
  logic [ADDR_W-1:0] offset_s;

`ifdef BITREV_EN
  // Reverse the low log2(N) bits of the read index.
  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W:0] k);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) begin
      r[LOG2N-1-i] = k[i];
    end
    return r;
  endfunction
  assign offset_s = bitrev(issued_r);
`else
  assign offset_s = issued_r[ADDR_W-1:0];
`endif

  // Credit: slots already committed, minus a slot freed by a pop this cycle.
  assign valid_s = (count_r != '0);
  assign pop_s   = valid_s && bus.m_ready;
  assign occ_s   = {1'b0, count_r} + (CW+1)'(inflight_r) - (CW+1)'(pop_s);

  assign bus.ram_en   = issue_s;
  assign bus.ram_addr = base_r + offset_s;
  assign bus.ram_we   = 1'b0;
  assign bus.busy     = (state_r != IDLE);
  assign bus.done     = done_r;
  assign bus.m_valid  = valid_s;
  assign bus.m_data   = valid_s ? mem_r[rd_ptr_r] : 16'd0;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start_ok_s) state_s = FETCH; else state_s = IDLE;
      FETCH:   if (issue_s && (issued_r == LAST_IDX)) state_s = DRAIN; else state_s = FETCH;
      DRAIN:   if (last_s) state_s = IDLE; else state_s = DRAIN;
      default: state_s = IDLE;
    endcase
  end

  // FSM outputs: accept start, issue reads, detect the last accepted beat.
  always_comb begin
    start_ok_s = 1'b0;
    issue_s    = 1'b0;
    last_s     = 1'b0;
    case (state_r)
      IDLE:    start_ok_s = bus.start;
      FETCH:   issue_s    = (issued_r < NUM) && (occ_s < DEPTH);
      DRAIN:   last_s     = pop_s && (sent_r == LAST_IDX);
      default: start_ok_s = 1'b0;
    endcase
  end

  // Transfer counters, base latch, in-flight flag and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_r     <= '0;
      issued_r   <= '0;
      sent_r     <= '0;
      inflight_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      if (start_ok_s) begin
        base_r   <= bus.base_addr;
        issued_r <= '0;
        sent_r   <= '0;
      end else begin
        if (issue_s) issued_r <= issued_r + (ADDR_W+1)'(1);
        if (pop_s)   sent_r   <= sent_r + (ADDR_W+1)'(1);
      end
      inflight_r <= issue_s;
      done_r     <= last_s;
    end
  end

  // Output FIFO: push RAM data one cycle after the read, pop on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_D; i++) begin
        mem_r[i] <= 16'd0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (inflight_r) begin
        mem_r[wr_ptr_r] <= bus.ram_dout;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_r + CW'(inflight_r) - CW'(pop_s);
    end
  end
endmodule

// File: tb/tb_poly_ram_streamer.sv
// Self-checking bench for poly_ram_streamer (N=8, ADDR_W=11, FIFO_D=4).
// A queue-based model predicts the address and data sequence of a transfer;
// one negedge process checks every read issue and every accepted beat.
module tb_poly_ram_streamer;
  localparam int N      = 8;
  localparam int ADDR_W = 11;
  localparam int FIFO_D = 4;

`ifdef BITREV_EN
  localparam logic [15:0] LIT_T1 [8] = '{16'd0, 16'd4, 16'd2, 16'd6, 16'd1, 16'd5, 16'd3, 16'd7};
  localparam logic [15:0] LIT_T3 [8] = '{16'd2044, 16'd0, 16'd2046, 16'd2, 16'd2045, 16'd1, 16'd2047, 16'd3};
`else
  localparam logic [15:0] LIT_T1 [8] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
  localparam logic [15:0] LIT_T3 [8] = '{16'd2044, 16'd2045, 16'd2046, 16'd2047, 16'd0, 16'd1, 16'd2, 16'd3};
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  poly_ram_streamer_if #(.ADDR_W(ADDR_W)) bus ();

  poly_ram_streamer #(.N(N), .ADDR_W(ADDR_W), .FIFO_D(FIFO_D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM model.
  logic [15:0] ram [2048];
  always @(posedge clk) begin
    if (bus.ram_en) bus.ram_dout <= ram[bus.ram_addr];
  end

  logic [10:0] exp_addr [$];
  logic [15:0] exp_data [$];
  logic [15:0] rx [$];
  int rd_issued, rd_accepted, done_cnt, first_valid, done_t;
  bit stall_prev;
  logic [15:0] prev_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

`ifdef BITREV_EN
  function automatic int ord(input int k);
    int r;
    r = 0;
    for (int i = 0; i < $clog2(N); i++) r = r * 2 + ((k >> i) & 1);
    return r;
  endfunction
`else
  function automatic int ord(input int k);
    return k;
  endfunction
`endif

  // Predict a full transfer from base.
  task automatic load(input logic [10:0] base);
    logic [10:0] a;
    exp_addr.delete();
    exp_data.delete();
    rx.delete();
    rd_issued = 0;
    rd_accepted = 0;
    done_cnt = 0;
    for (int k = 0; k < N; k++) begin
      a = 11'((int'(base) + ord(k)) % 2048);
      exp_addr.push_back(a);
      exp_data.push_back(ram[a]);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      check("ram_we", bus.ram_we, 1'b0);
      check("credit", ((rd_issued + int'(bus.ram_en) - rd_accepted
                        - int'(bus.m_valid && bus.m_ready)) <= FIFO_D), 1'b1);
      if (stall_prev) begin
        check("stall_valid", bus.m_valid, 1'b1);
        check("stall_data", bus.m_data, prev_data);
      end
      if (bus.ram_en) begin
        if (exp_addr.size() == 0) check("unexpected_read", 1'b1, 1'b0);
        else check("ram_addr", bus.ram_addr, exp_addr.pop_front());
        rd_issued++;
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_data.size() == 0) check("extra_beat", 1'b1, 1'b0);
        else check("m_data", bus.m_data, exp_data.pop_front());
        rx.push_back(bus.m_data);
        rd_accepted++;
      end
      if (bus.done) done_cnt++;
      stall_prev = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
    end
  end

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"}, bus.busy, 1'b0);
    check({name, "_done"}, bus.done, 1'b0);
    check({name, "_ram_en"}, bus.ram_en, 1'b0);
    check({name, "_ram_addr"}, bus.ram_addr, 11'd0);
    check({name, "_m_valid"}, bus.m_valid, 1'b0);
    check({name, "_m_data"}, bus.m_data, 16'd0);
  endtask

  // One transfer; mode 1 toggles m_ready 1,0,0; stray pulses start while busy.
  task automatic xfer(input string name, input logic [10:0] base, input int mode, input bit stray);
    int t;
    bit seen;
    load(base);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = base; bus.m_ready = 1'b1;
    @(posedge clk);
    t = 0; seen = 1'b0; first_valid = -1; done_t = -1;
    while (!seen && t < 200) begin
      #1;
      bus.start     = stray && (t == 3 || t == 9);
      bus.base_addr = (stray && (t == 3 || t == 9)) ? 11'd100 : base;
      bus.m_ready   = (mode == 1) ? (t % 3 == 0) : 1'b1;
      @(negedge clk);
      if (first_valid < 0 && bus.m_valid) first_valid = t;
      if (bus.done) begin seen = 1'b1; done_t = t; end
      @(posedge clk);
      t++;
    end
    check({name, "_done_seen"}, seen, 1'b1);
    #1; bus.start = 1'b0; bus.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check({name, "_busy_after"}, bus.busy, 1'b0);
    check({name, "_done_count"}, done_cnt, 1);
    check({name, "_beats"}, rx.size(), N);
    check({name, "_left_data"}, exp_data.size(), 0);
    check({name, "_left_addr"}, exp_addr.size(), 0);
  endtask

  task automatic check_lit(input string name, input logic [15:0] lit [8]);
    for (int k = 0; k < N; k++) begin
      check({name, "_lit"}, (k < rx.size()) ? rx[k] : 16'hDEAD, lit[k]);
    end
  endtask

  initial begin
    int t;
    for (int i = 0; i < 2048; i++) ram[i] = 16'(i);
    bus.start = 1'b0; bus.base_addr = 11'd0; bus.m_ready = 1'b0; bus.ram_dout = 16'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1; rst = 1'b0;

    // T1: natural order, back-to-back.
    xfer("t1", 11'd0, 0, 1'b0);
    check("t1_first_valid", first_valid, 2);
    check("t1_done_cycle", done_t, 10);
    check_lit("t1", LIT_T1);

    // T2: back-pressure pattern.
    xfer("t2", 11'd0, 1, 1'b0);
    check("t2_first_valid", first_valid, 2);
    check_lit("t2", LIT_T1);

    // T3: address wrap past the top.
    xfer("t3", 11'd2044, 0, 1'b0);
    check_lit("t3", LIT_T3);

    // T4: reset after 3 beats, then a clean full transfer.
    load(11'd0);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = 11'd0; bus.m_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    t = 0;
    while (rd_accepted < 3 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("t4_sent", rd_accepted, 3);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("t4_rst");
    exp_addr.delete();
    exp_data.delete();
    @(posedge clk); #1; rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t4_no_done", done_cnt, 0);
    check("t4_idle", bus.busy, 1'b0);
    xfer("t4b", 11'd0, 0, 1'b0);
    check_lit("t4b", LIT_T1);

    // T5: start while busy (incl. last-beat cycle) is ignored.
    xfer("t5", 11'd0, 0, 1'b1);
    check("t5_done_cycle", done_t, 10);
    check_lit("t5", LIT_T1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
